// File: rtl/idct8_transpose_buf.sv
// idct8_transpose_buf
//   8x8 ping-pong transpose buffer between the row and column passes of the
//   8-point IDCT. Rows arrive one per accepted beat on data_in_1..8, where
//   lane k is column k-1. Once a block of 8 rows is complete, it leaves
//   column by column on data_out_1..8, where lane k is row k-1. While one
//   bank is being read, the other bank is being written.
//
// Optional feature macro: IDCT_MID_SHIFT_EN
//   When defined, each lane is stored as clip16((x + 64) >>> 7),
//   sign-extended to DATA_W. When undefined, lanes pass through bit-exact.
//
// Ports:
//   clk                  rising-edge clock
//   reset                asynchronous, active-high reset
//   in_valid             a row beat is present on data_in_1..8
//   data_in_1..8         row lanes (signed, DATA_W bits)
//   out_valid            a column beat is present on data_out_1..8
//   blk_first            high with column 0 of each block
//   data_out_1..8        column lanes (signed, DATA_W bits); hold when idle
module idct8_transpose_buf #(
    parameter int DATA_W = 25,
    parameter int N      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data_in_1,
    input  logic [DATA_W-1:0] data_in_2,
    input  logic [DATA_W-1:0] data_in_3,
    input  logic [DATA_W-1:0] data_in_4,
    input  logic [DATA_W-1:0] data_in_5,
    input  logic [DATA_W-1:0] data_in_6,
    input  logic [DATA_W-1:0] data_in_7,
    input  logic [DATA_W-1:0] data_in_8,
    output logic              out_valid,
    output logic              blk_first,
    output logic [DATA_W-1:0] data_out_1,
    output logic [DATA_W-1:0] data_out_2,
    output logic [DATA_W-1:0] data_out_3,
    output logic [DATA_W-1:0] data_out_4,
    output logic [DATA_W-1:0] data_out_5,
    output logic [DATA_W-1:0] data_out_6,
    output logic [DATA_W-1:0] data_out_7,
    output logic [DATA_W-1:0] data_out_8
);

    localparam int RowW = $clog2(N);
    localparam logic [RowW-1:0] LastIdx = RowW'(N - 1);

    typedef enum logic {
        st_idle,
        st_read
    } state_t;

    // Lane transform applied on the write path.
    function automatic logic [DATA_W-1:0] lane_xform(input logic [DATA_W-1:0] x);
`ifdef IDCT_MID_SHIFT_EN
        logic signed [DATA_W:0] sum;
        logic signed [DATA_W:0] rnd;
        logic signed [DATA_W:0] sh;
        logic signed [DATA_W:0] hi;
        logic signed [DATA_W:0] lo;
        rnd = (DATA_W + 1)'(64);
        hi  = (DATA_W + 1)'(32767);
        lo  = (DATA_W + 1)'(-32768);
        // One guard bit keeps the rounding add from overflowing.
        sum = {x[DATA_W-1], x};
        sum = sum + rnd;
        sh  = sum >>> 7;
        if (sh > hi) begin
            sh = hi;
        end else if (sh < lo) begin
            sh = lo;
        end
        return sh[DATA_W-1:0];
`else
        return x;
`endif
    endfunction

    logic [DATA_W-1:0] din   [N];
    logic [DATA_W-1:0] wdata [N];
    logic [DATA_W-1:0] dout_q[N];

    // Bank contents carry no reset; only the control state is cleared.
    logic [DATA_W-1:0] mem [2][N][N];

    logic [RowW-1:0] wr_row_q;
    logic            wr_bank_q;
    logic            blk_done;

    state_t          state_q, state_d;
    logic            rd_bank_q, rd_bank_d;
    logic [RowW-1:0] rd_col_q, rd_col_d;
    logic            pending_q, pending_d;

    assign din[0] = data_in_1;
    assign din[1] = data_in_2;
    assign din[2] = data_in_3;
    assign din[3] = data_in_4;
    assign din[4] = data_in_5;
    assign din[5] = data_in_6;
    assign din[6] = data_in_7;
    assign din[7] = data_in_8;

    assign data_out_1 = dout_q[0];
    assign data_out_2 = dout_q[1];
    assign data_out_3 = dout_q[2];
    assign data_out_4 = dout_q[3];
    assign data_out_5 = dout_q[4];
    assign data_out_6 = dout_q[5];
    assign data_out_7 = dout_q[6];
    assign data_out_8 = dout_q[7];

    always_comb begin
        for (int c = 0; c < N; c++) begin
            wdata[c] = lane_xform(din[c]);
        end
    end

    // The edge that accepts the last row of a block hands that bank to the read side.
    assign blk_done = in_valid && (wr_row_q == LastIdx);

    // Write side
    always_ff @(posedge clk) begin
        if (in_valid) begin
            for (int c = 0; c < N; c++) begin
                mem[wr_bank_q][wr_row_q][c] <= wdata[c];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_row_q  <= '0;
            wr_bank_q <= 1'b0;
        end else if (in_valid) begin
            wr_row_q <= wr_row_q + 1'b1;
            if (wr_row_q == LastIdx) begin
                wr_bank_q <= ~wr_bank_q;
            end
        end
    end

    // Read side
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= st_idle;
            rd_bank_q <= 1'b0;
            rd_col_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_bank_q <= rd_bank_d;
            rd_col_q  <= rd_col_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        rd_col_d  = rd_col_q;
        pending_d = pending_q;
        unique case (state_q)
            st_idle: begin
                if (blk_done) begin
                    state_d   = st_read;
                    rd_bank_d = wr_bank_q;
                    rd_col_d  = '0;
                end
            end
            st_read: begin
                rd_col_d = rd_col_q + 1'b1;
                if (rd_col_q == LastIdx) begin
                    // Only two banks exist, so the next completed bank is always the other one.
                    if (pending_q || blk_done) begin
                        rd_bank_d = ~rd_bank_q;
                        rd_col_d  = '0;
                        pending_d = 1'b0;
                    end else begin
                        state_d = st_idle;
                    end
                end else if (blk_done) begin
                    pending_d = 1'b1;
                end
            end
            default: begin
                state_d = st_idle;
            end
        endcase
    end

    // Registered column output; data holds while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            blk_first <= 1'b0;
            for (int k = 0; k < N; k++) begin
                dout_q[k] <= '0;
            end
        end else begin
            out_valid <= (state_q == st_read);
            blk_first <= (state_q == st_read) && (rd_col_q == '0);
            if (state_q == st_read) begin
                for (int k = 0; k < N; k++) begin
                    dout_q[k] <= mem[rd_bank_q][k][rd_col_q];
                end
            end
        end
    end

endmodule
